// File: rtl/warp_fetch_unit.sv
// Warp fetch stage: holds the warp PC, reads the instruction ROM and buffers {inst, pc} for decode.
// Optional perf counters (fetch_count / stall_count) are built when FETCH_PERF_CNT_EN is defined.
module warp_fetch_unit #(
    parameter int          PC_WIDTH    = 8,
    parameter int          INST_WIDTH  = 16,
    parameter int          IBUF_DEPTH  = 4,
    parameter logic [3:0]  EXIT_OPCODE = 4'b0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PC_WIDTH-1:0]   start_pc,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [INST_WIDTH-1:0] imem_data,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst_data,
    output logic [PC_WIDTH-1:0]   inst_pc,
    output logic                  busy,
    output logic                  done
`ifdef FETCH_PERF_CNT_EN
   ,output logic [15:0]           fetch_count,
    output logic [15:0]           stall_count
`endif
);
    localparam int PTR_W = $clog2(IBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t                                 state_q, state_d;
    logic [PC_WIDTH-1:0]                    pc_q, pc_d;
    logic [PTR_W-1:0]                       head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]                       cnt_q, cnt_d;
    logic [IBUF_DEPTH-1:0][INST_WIDTH-1:0]  ibuf_inst_q;
    logic [IBUF_DEPTH-1:0][PC_WIDTH-1:0]    ibuf_pc_q;

    logic push, pop, clr, not_full;

    assign not_full = (cnt_q < CNT_W'(IBUF_DEPTH));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        clr     = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    pc_d    = {start_pc[PC_WIDTH-1:1], 1'b0};
                    state_d = S_FETCH;
                end
            end
            S_FETCH, S_DRAIN: begin
                // Redirect wins over push and pop; a head handshaken now is dropped.
                if (redirect_valid) begin
                    clr     = 1'b1;
                    pc_d    = {redirect_pc[PC_WIDTH-1:1], 1'b0};
                    state_d = S_FETCH;
                end else begin
                    pop = (cnt_q != '0) && inst_ready;
                    if (state_q == S_FETCH && not_full) begin
                        push = 1'b1;
                        if (imem_data[INST_WIDTH-1 -: 4] == EXIT_OPCODE)
                            state_d = S_DRAIN;
                        else
                            pc_d = pc_q + PC_WIDTH'(2);
                    end
                    if (state_q == S_DRAIN && pop && cnt_q == CNT_W'(1))
                        state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (clr) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            head_d = head_q + PTR_W'(pop);
            tail_d = tail_q + PTR_W'(push);
            cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            ibuf_inst_q <= '0;
            ibuf_pc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            if (push) begin
                ibuf_inst_q[tail_q] <= imem_data;
                ibuf_pc_q[tail_q]   <= pc_q;
            end
        end
    end

    assign imem_addr  = pc_q;
    assign inst_valid = (cnt_q != '0);
    assign inst_data  = ibuf_inst_q[head_q];
    assign inst_pc    = ibuf_pc_q[head_q];
    assign busy       = (state_q == S_FETCH) || (state_q == S_DRAIN);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || (state_q == S_IDLE && start)) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push && fetch_cnt_q != 16'hFFFF)
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            if (state_q == S_FETCH && !not_full && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_warp_fetch_unit.sv
// Directed bench for warp_fetch_unit: kernel run, backpressure, redirect, PC wrap, reset in DRAIN.
module tb_warp_fetch_unit;
    logic        clk = 1'b0;
    logic        rst, start, redirect_valid, inst_ready;
    logic [7:0]  start_pc, redirect_pc, imem_addr, inst_pc;
    logic [15:0] imem_data, inst_data;
    logic        inst_valid, busy, done;
    logic [15:0] rom [0:127];
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count, stall_count;
`endif

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;
    assign imem_data = rom[imem_addr[7:1]];

    warp_fetch_unit dut (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc), .busy(busy), .done(done)
`ifdef FETCH_PERF_CNT_EN
       ,.fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_pc = '0; redirect_valid = 1'b0;
        redirect_pc = '0; inst_ready = 1'b0;
        clear_rom();
        tick(); tick();
        chk("rst_addr",  imem_addr,  0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_data",  inst_data,  0);
        chk("rst_pc",    inst_pc,    0);
        chk("rst_busy",  busy,       0);
        chk("rst_done",  done,       0);
        rst = 1'b0;
        tick();

        // Basic 4-instruction kernel, decode always ready
        rom[0] = 16'h1123; rom[1] = 16'h2456; rom[2] = 16'h8A0F; rom[3] = 16'h0000;
        inst_ready = 1'b1; start_pc = 8'h00; start = 1'b1;
        tick(); start = 1'b0;                       // cycle N+1
        chk("k1_busy", busy, 1);
        chk("k1_addr0", imem_addr, 8'h00);
        chk("k1_nv", inst_valid, 0);
        tick();                                     // cycle N+2
        chk("k1_v0", inst_valid, 1);
        chk("k1_d0", inst_data, 16'h1123);
        chk("k1_p0", inst_pc, 8'h00);
        tick();
        chk("k1_d1", inst_data, 16'h2456);
        chk("k1_p1", inst_pc, 8'h02);
        tick();
        chk("k1_d2", inst_data, 16'h8A0F);
        chk("k1_p2", inst_pc, 8'h04);
        tick();
        chk("k1_v3", inst_valid, 1);
        chk("k1_d3", inst_data, 16'h0000);
        chk("k1_p3", inst_pc, 8'h06);
        chk("k1_addr_hold", imem_addr, 8'h06);
        chk("k1_nodone", done, 0);
        tick();
        chk("k1_done", done, 1);
        chk("k1_busy_off", busy, 0);
        chk("k1_empty", inst_valid, 0);
        tick();
        chk("k1_done_pulse", done, 0);
        chk("k1_idle", busy, 0);

        // Backpressure: buffer fills, pc holds at 0x08, then in-order drain
        rom[3] = 16'h3333; rom[4] = 16'h0000;
        inst_ready = 1'b0; start = 1'b1;
        tick(); start = 1'b0;                       // cycle N+1
`ifdef FETCH_PERF_CNT_EN
        chk("bp_fc_clr", fetch_count, 0);
`endif
        repeat (10) tick();                         // cycle N+11
        chk("bp_addr", imem_addr, 8'h08);
        chk("bp_busy", busy, 1);
        chk("bp_v", inst_valid, 1);
        chk("bp_p0", inst_pc, 8'h00);
        chk("bp_d0", inst_data, 16'h1123);
        inst_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("bp_drain_v", inst_valid, 1);
            chk("bp_drain_pc", inst_pc, 8'(2 * i));
        end
        chk("bp_exit", inst_data, 16'h0000);
        tick();
        chk("bp_done", done, 1);
`ifdef FETCH_PERF_CNT_EN
        chk("bp_fetch_count", fetch_count, 5);
        chk("bp_stall_count", stall_count, 7);
`endif
        tick();

        // Redirect with 3 buffered entries and a head handshake in the same cycle
        rom[4] = 16'h4444; rom[16] = 16'hA020; rom[17] = 16'hA022; rom[18] = 16'h0000;
        inst_ready = 1'b0; start = 1'b1;
        tick(); start = 1'b0;                       // cycle N+1
`ifdef FETCH_PERF_CNT_EN
        chk("rd_fc_clr", fetch_count, 0);
        chk("rd_sc_clr", stall_count, 0);
`endif
        tick(); tick(); tick();                     // cycle N+4, 3 entries
        chk("rd_head", inst_pc, 8'h00);
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h21;
        tick(); redirect_valid = 1'b0;
        chk("rd_flushed", inst_valid, 0);
        chk("rd_addr", imem_addr, 8'h20);
        chk("rd_busy", busy, 1);
        tick();
        chk("rd_v", inst_valid, 1);
        chk("rd_p0", inst_pc, 8'h20);
        chk("rd_d0", inst_data, 16'hA020);
        tick();
        chk("rd_p1", inst_pc, 8'h22);
        tick();
        chk("rd_p2", inst_pc, 8'h24);
        tick();
        chk("rd_done", done, 1);
        tick();

        // PC wrap 0xFC -> 0xFE -> 0x00
        clear_rom();
        rom[126] = 16'hB0FC; rom[127] = 16'hB0FE; rom[0] = 16'hB000; rom[1] = 16'h0000;
        start_pc = 8'hFC; start = 1'b1;
        tick(); start = 1'b0;
        chk("wr_addr", imem_addr, 8'hFC);
        tick();
        chk("wr_p0", inst_pc, 8'hFC);
        chk("wr_d0", inst_data, 16'hB0FC);
        tick();
        chk("wr_p1", inst_pc, 8'hFE);
        tick();
        chk("wr_p2", inst_pc, 8'h00);
        chk("wr_d2", inst_data, 16'hB000);
        tick();
        chk("wr_p3", inst_pc, 8'h02);
        tick();
        chk("wr_done", done, 1);
        tick();

        // Reset in DRAIN with 2 entries; start while busy is ignored
        rom[0] = 16'h1111; rom[1] = 16'h0000;
        inst_ready = 1'b0; start_pc = 8'h00; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();                             // DRAIN, 2 entries
        chk("rs_busy", busy, 1);
        start_pc = 8'h40; start = 1'b1;
        tick(); start = 1'b0;
        chk("rs_ign_addr", imem_addr, 8'h02);
        chk("rs_ign_pc", inst_pc, 8'h00);
        chk("rs_ign_busy", busy, 1);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("rs_valid", inst_valid, 0);
        chk("rs_busy_off", busy, 0);
        chk("rs_addr", imem_addr, 8'h00);
        chk("rs_nodone", done, 0);
        tick();
        chk("rs_nodone2", done, 0);
        chk("rs_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
